// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type, frame constants and baud helper
package uart_pkg;

    // Bits on the wire per frame and bits actually carried from the fabric
    localparam int FRAME_DATA_BITS = 8;
    localparam int PAYLOAD_BITS    = 4;

    // Transmit sequence; CS guard periods wrap the classic 8N1 frame
    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        START,
        DATA,
        STOP,
        CS_HOLD
    } uart_state_e;

    // Whole clock cycles per bit; integer division truncates any fraction
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with a one-cycle tick at each wrap
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear realigns the bit grid to the current edge; otherwise count and wrap
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_cs.sv
// rtl/uart_tx_cs.sv - 8N1 UART transmitter with active-low chip select framing
module uart_tx_cs
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [PAYLOAD_BITS-1:0] data,
    output logic                    tx,
    output logic                    cs,
    output logic                    busy,
    output logic                    done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx_cs: CLK_FREQ/BAUD must be at least 2");
    end

    uart_state_e                state_q;
    logic [FRAME_DATA_BITS-1:0] shift_q;
    logic [2:0]                 bit_cnt_q;
    logic                       tx_q;
    logic                       cs_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       accept;
    logic                       bit_tick;

    // A request is only honoured from IDLE; anything else is dropped, not queued
    assign accept = (state_q == IDLE) && start;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (accept),
        .tick   (bit_tick)
    );

    // Frame sequencer: every output is driven from this register set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q   <= {{(FRAME_DATA_BITS - PAYLOAD_BITS){1'b0}}, data};
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b1;
                        cs_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (bit_tick) begin
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        state_q <= CS_HOLD;
                    end
                end
                CS_HOLD: begin
                    if (bit_tick) begin
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    cs_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign cs   = cs_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_cs.sv
// tb/tb_uart_tx_cs.sv - scoreboard bench: stimulus queues frames, monitor decodes the line
module tb_uart_tx_cs;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] data    = 4'h0;
    logic       tx;
    logic       cs;
    logic       busy;
    logic       done;

    uart_tx_cs #(
        .CLK_FREQ(1000),
        .BAUD    (100)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .data   (data),
        .tx     (tx),
        .cs     (cs),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor: bench-side receiver ----------------
    bit         in_frame  = 1'b0;
    bit         prev_done = 1'b0;
    int         k         = 0;
    int         bad_tx    = 0;
    int         bad_busy  = 0;
    logic [7:0] rx        = 8'h00;
    logic       bit_ref   = 1'b1;

    task automatic sample_bit();
        int b;
        int p;
        b = k / 10;
        p = k % 10;
        if (busy !== 1'b1) bad_busy++;
        if (p == 0) bit_ref = tx;
        else if (tx !== bit_ref) bad_tx++;
        if (p == 5) begin
            case (b)
                0:       check("guard_pre", tx, 1);
                1:       check("start_bit", tx, 0);
                10:      check("stop_bit", tx, 1);
                11:      check("guard_post", tx, 1);
                default: if (b >= 2 && b <= 9) rx[b-2] = tx;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            in_frame  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("done_width", done, 0);
            prev_done = done;
            if (in_frame) begin
                if (cs === 1'b1) begin
                    check("cs_low_len", k + 1, 120);
                    check("done_at_end", done, 1);
                    check("busy_at_end", busy, 0);
                    check("tx_stable", bad_tx, 0);
                    check("busy_in_frame", bad_busy, 0);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got byte %02h, required no frame", rx);
                    end else begin
                        check("rx_byte", rx, exp_q.pop_front());
                    end
                    in_frame = 1'b0;
                end else begin
                    k++;
                    if (k > 200) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL frame_timeout: cs low %0d cycles, required 120", k);
                        in_frame = 1'b0;
                    end else begin
                        sample_bit();
                    end
                end
            end else if (cs === 1'b0) begin
                in_frame = 1'b1;
                k        = 0;
                rx       = 8'h00;
                bad_tx   = 0;
                bad_busy = 0;
                sample_bit();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [3:0] d);
        start = 1'b1;
        data  = d;
        exp_q.push_back({4'h0, d});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        check(name, got, 1);
    endtask

    initial begin
        int bad;
        int dcount;

        repeat (3) @(negedge clk);
        check("reset_state", {tx, cs, busy, done}, 4'b1100);
        reset_n = 1'b1;

        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({tx, cs, busy, done} !== 4'b1100) bad++;
        end
        check("idle_50", bad, 0);

        // single frame, payload A
        send(4'hA);
        wait_done("done_A");
        @(negedge clk);

        // second request and data change while busy are both ignored
        start = 1'b1;
        data  = 4'hF;
        exp_q.push_back(8'h0F);
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        start = 1'b1;
        data  = 4'h3;
        @(negedge clk);
        start = 1'b0;
        wait_done("done_F");
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (cs !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        check("no_second_frame", bad, 0);

        // start tied high: back-to-back frames with one idle cycle
        start = 1'b1;
        data  = 4'h5;
        repeat (3) exp_q.push_back(8'h05);
        dcount = 0;
        for (int i = 0; i < 1000 && dcount < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcount++;
                if (dcount == 3) begin
                    start = 1'b0;
                end else begin
                    @(negedge clk);
                    check("b2b_gap", cs, 0);
                end
            end
        end
        check("b2b_frames", dcount, 3);
        @(negedge clk);

        // asynchronous reset in the middle of the data bits
        start = 1'b1;
        data  = 4'h6;
        @(negedge clk);
        start = 1'b0;
        repeat (64) @(negedge clk);
        check("busy_before_rst", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst_async", {tx, cs, busy, done}, 4'b1100);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if ({tx, cs, busy, done} !== 4'b1100) bad++;
        end
        check("idle_after_rst", bad, 0);

        // every payload value
        for (int d = 0; d < 16; d++) begin
            send(d[3:0]);
            wait_done("done_sweep");
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_cs.md
Name: uart_tx_cs

Overview:
UART transmitter, 8N1 framing, LSB first, carrying a 4-bit payload zero-extended to 8 bits. Drives a chip-select alongside TX so the far end (Arduino or a uart_rx-style receiver) qualifies the frame exactly as our receiver does: cs low means frame valid. Sits in the FPGA top level beside the receiver, giving the return path FPGA TX -> Arduino RX.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
CLKS_PER_BIT, CLK_FREQ/BAUD (5208 at defaults), localparam; elaboration error if < 2

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous, active-low reset
start  input  1  request to send; sampled only in IDLE
data  input  4  payload; latched on the accepting cycle
tx  output  1  serial line, idle high
cs  output  1  chip select, active low, high when idle
busy  output  1  high while a transaction is in progress
done  output  1  one-cycle pulse at end of transaction

Behaviour:
- Reset (async, reset_n=0): state IDLE, tx=1, cs=1, busy=0, done=0, counters cleared. Takes effect immediately mid-frame, even mid-bit. No partial frame is resumed after reset release.
- All outputs are registered.
- FSM states: IDLE -> CS_SETUP -> START -> DATA -> STOP -> CS_HOLD -> IDLE.
- Each of CS_SETUP, START, STOP and CS_HOLD lasts exactly CLKS_PER_BIT cycles. DATA lasts 8*CLKS_PER_BIT cycles.
- IDLE:
  - tx=1, cs=1, busy=0.
  - If start=1 on edge N: latch shift = {4'b0000, data}, enter CS_SETUP.
  - From cycle N+1: cs=0, busy=1.
- CS_SETUP: tx=1, cs=0. This is the guard time before the start bit.
- START: tx=0.
- DATA:
  - tx = shift[0]; shift right once per bit time.
  - bit counter runs 0..7 and must not wrap past 7.
- STOP: tx=1.
- CS_HOLD: tx=1, cs=0. This is the guard time after the stop bit.
- Leaving CS_HOLD:
  - state goes to IDLE; cs=1, busy=0 and done=1 all in the same cycle.
  - done drops the next cycle.
  - Total timing: busy high for exactly 12*CLKS_PER_BIT cycles; cs low for the same window.
- start while busy=1: ignored, not queued. data changes while busy: no effect on the frame in flight.
- start=1 in the cycle done=1 (back-to-back): accepted, because the state is IDLE. cs then stays high for exactly that one cycle between frames.
- start held high continuously: frames repeat with one idle cycle between them.
- Baud counter:
  - counts 0..CLKS_PER_BIT-1 and wraps to 0 while raising a one-cycle bit_tick.
  - reset to 0 on frame accept, so bit timing is aligned to the accept edge with no partial first bit.
- Width rules:
  - baud counter width = $clog2(CLKS_PER_BIT).
  - bit counter is 3 bits.
  - upper nibble of the frame is always 0.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef (IDLE, CS_SETUP, START, DATA, STOP, CS_HOLD)
  - FRAME_DATA_BITS=8 and PAYLOAD_BITS=4
  - a function clks_per_bit(clk_freq, baud)
  - The receiver is migrated to this package later.
- One sub-module, uart_baud_gen:
  - parameter CLKS_PER_BIT
  - inputs clk, reset_n, clear
  - output tick
  - reusable by the receiver.

Test Plan (bench uses CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10):
- Reset then idle 50 cycles -> tx=1, cs=1, busy=0, done=0 throughout.
- start pulse with data=4'hA -> cs low 120 cycles; tx low for cycles 11-20 (start bit); data bits 0,1,0,1,0,0,0,0 at 10 cycles each; stop bit high; done pulse at cycle 121.
- data=4'hF, start held 1 cycle, then start re-pulsed at cycle 50 with data=4'h3 -> second request ignored; serial bits decode to 0x0F, no second frame.
- start tied high, data=4'h5 -> consecutive frames 0x05; cs high for exactly 1 cycle between frames; done coincides with that cycle.
- reset_n dropped at cycle 65 (mid-DATA) -> tx=1, cs=1, busy=0 in the same cycle (async); after release with no start, the line stays idle.
- Bench receiver sampling at mid-bit decodes every data 0..15 -> recovered nibble equals the sent nibble; upper nibble 0.
